// File: rtl/time_entry_ctrl.sv
// -----------------------------------------------------------------------------
// time_entry_ctrl
//
// Keypad time-entry controller for the microwave timer. Decimal key presses
// are shifted into a four-digit BCD MM:SS value. On START the value is
// checked (seconds tens digit must be 0..5 and the value must be non-zero).
// A good value is parallel-loaded into the down-counter chain with a
// one-cycle active-low loadn pulse, after which count_en runs the chain until
// it reports zero or the user presses CANCEL.
//
// Ports
//   clock        system clock, rising edge
//   clear        synchronous active-high reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     0-9 digit, KEY_START, KEY_CANCEL; any other code is ignored
//   timer_zero   all counter digits are zero (from the counter chain)
//   digits       {min_tens, min_ones, sec_tens, sec_ones} BCD to the counters
//   loadn        active-low parallel load, one-cycle pulse
//   count_en     enable for the least-significant counter digit
//   digit_count  number of digits entered, 0..4
//   running      high while the countdown runs
//   entry_err    one-cycle pulse, START rejected
//   done         one-cycle pulse, countdown finished
//
// All outputs are registered and change on the edge that samples the event.
// -----------------------------------------------------------------------------
module time_entry_ctrl #(
   parameter logic [3:0] KEY_START  = 4'hA,
   parameter logic [3:0] KEY_CANCEL = 4'hB
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        timer_zero,
   output logic [15:0] digits,
   output logic        loadn,
   output logic        count_en,
   output logic [2:0]  digit_count,
   output logic        running,
   output logic        entry_err,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      LOAD  = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [15:0] digits_n;
   logic [2:0]  count_n;
   logic        err_n;
   logic        done_n;

   // High during the first cycle spent in RUN; the counters have only just
   // been loaded, so timer_zero is not trusted at the end of that cycle.
   logic        first_run;

   logic        is_digit;
   logic        is_start;
   logic        is_cancel;

   assign is_digit  = key_valid && (key_code <= 4'd9);
   assign is_start  = key_valid && (key_code == KEY_START);
   assign is_cancel = key_valid && (key_code == KEY_CANCEL);

   // Next-state and next-output decode
   always_comb begin
      state_n  = state;
      digits_n = digits;
      count_n  = digit_count;
      err_n    = 1'b0;
      done_n   = 1'b0;

      case (state)
         IDLE: begin
            if (is_digit) begin
               digits_n = {12'h000, key_code};
               count_n  = 3'd1;
               state_n  = ENTRY;
            end
         end

         ENTRY: begin
            if (is_digit) begin
               // A fifth digit is dropped so the first four entered survive.
               if (digit_count < 3'd4) begin
                  digits_n = {digits[11:0], key_code};
                  count_n  = digit_count + 3'd1;
               end
            end else if (is_start) begin
               if ((digits[7:4] > 4'd5) || (digits == 16'h0000)) begin
                  err_n = 1'b1;
               end else begin
                  state_n = LOAD;
               end
            end else if (is_cancel) begin
               state_n  = IDLE;
               digits_n = 16'h0000;
               count_n  = 3'd0;
            end
         end

         LOAD: begin
            state_n = RUN;
         end

         RUN: begin
            // CANCEL outranks timer_zero: a cancelled run never reports done.
            if (is_cancel) begin
               state_n  = IDLE;
               digits_n = 16'h0000;
               count_n  = 3'd0;
            end else if (timer_zero && !first_run) begin
               done_n   = 1'b1;
               state_n  = IDLE;
               digits_n = 16'h0000;
               count_n  = 3'd0;
            end
         end

         default: begin
            state_n  = IDLE;
            digits_n = 16'h0000;
            count_n  = 3'd0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (clear) begin
         state       <= IDLE;
         digits      <= 16'h0000;
         digit_count <= 3'd0;
         loadn       <= 1'b1;
         count_en    <= 1'b0;
         running     <= 1'b0;
         entry_err   <= 1'b0;
         done        <= 1'b0;
         first_run   <= 1'b0;
      end else begin
         state       <= state_n;
         digits      <= digits_n;
         digit_count <= count_n;
         loadn       <= (state_n != LOAD);
         count_en    <= (state_n == RUN);
         running     <= (state_n == RUN);
         entry_err   <= err_n;
         done        <= done_n;
         first_run   <= (state_n == RUN) && (state != RUN);
      end
   end

endmodule

// File: tb/tb_time_entry_ctrl.sv
module tb_time_entry_ctrl;

   logic        clock;
   logic        clear;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        timer_zero;
   logic [15:0] digits;
   logic        loadn;
   logic        count_en;
   logic [2:0]  digit_count;
   logic        running;
   logic        entry_err;
   logic        done;

   localparam logic [3:0] KS = 4'hA;
   localparam logic [3:0] KC = 4'hB;

   time_entry_ctrl #(.KEY_START(KS), .KEY_CANCEL(KC)) dut (
      .clock       (clock),
      .clear       (clear),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .timer_zero  (timer_zero),
      .digits      (digits),
      .loadn       (loadn),
      .count_en    (count_en),
      .digit_count (digit_count),
      .running     (running),
      .entry_err   (entry_err),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [23:0] vec;   // {digits, digit_count, loadn, running, count_en, entry_err, done}
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Monitor: one registered response per clock edge, checked 1 time unit
   // after the edge against the oldest queued expectation.
   initial begin
      exp_t        e;
      logic [23:0] act;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {digits, digit_count, loadn, running, count_en, entry_err, done};
            n_vec++;
            if (act !== e.vec) begin
               n_bad++;
               $display("FAIL %s: got digits=%h cnt=%0d loadn=%b run=%b cen=%b err=%b done=%b, want digits=%h cnt=%0d loadn=%b run=%b cen=%b err=%b done=%b",
                        e.name, act[23:8], act[7:5], act[4], act[3], act[2], act[1], act[0],
                        e.vec[23:8], e.vec[7:5], e.vec[4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
            end
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs required after the edge.
   task automatic st(input logic clr, input logic kv, input logic [3:0] code,
                     input logic tz, input logic [15:0] d, input logic [2:0] c,
                     input logic ld, input logic run, input logic err,
                     input logic dn, input string name);
      exp_t e;
      clear      = clr;
      key_valid  = kv;
      key_code   = code;
      timer_zero = tz;
      e.vec  = {d, c, ld, run, run, err, dn};
      e.name = name;
      sb.push_back(e);
      @(posedge clock);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear = 1'b1; key_valid = 1'b0; key_code = 4'h0; timer_zero = 1'b0;

      //   clr kv code tz  digits    cnt ld run err done
      st(1, 0, 4'h0, 0, 16'h0000, 0, 1, 0, 0, 0, "reset");
      st(1, 1, 4'h3, 1, 16'h0000, 0, 1, 0, 0, 0, "reset_hold");

      // IDLE ignores START, CANCEL and bad codes
      st(0, 1, KS,   0, 16'h0000, 0, 1, 0, 0, 0, "idle_start");
      st(0, 1, KC,   0, 16'h0000, 0, 1, 0, 0, 0, "idle_cancel");
      st(0, 1, 4'hE, 0, 16'h0000, 0, 1, 0, 0, 0, "idle_bad");

      // Load path 1,3,0,START, back-to-back keys
      st(0, 1, 4'h1, 0, 16'h0001, 1, 1, 0, 0, 0, "lp_k1");
      st(0, 1, 4'h3, 0, 16'h0013, 2, 1, 0, 0, 0, "lp_k3");
      st(0, 1, 4'h0, 0, 16'h0130, 3, 1, 0, 0, 0, "lp_k0");
      st(0, 1, KS,   0, 16'h0130, 3, 0, 0, 0, 0, "lp_load");
      st(0, 1, 4'h7, 0, 16'h0130, 3, 1, 1, 0, 0, "lp_run");
      st(0, 0, 4'h0, 1, 16'h0130, 3, 1, 1, 0, 0, "lp_tz_first");
      st(0, 1, KS,   0, 16'h0130, 3, 1, 1, 0, 0, "lp_run_start");
      st(0, 1, KC,   0, 16'h0000, 0, 1, 0, 0, 0, "lp_cancel");

      // Digit overflow
      st(0, 1, 4'h1, 0, 16'h0001, 1, 1, 0, 0, 0, "ov_k1");
      st(0, 1, 4'h2, 0, 16'h0012, 2, 1, 0, 0, 0, "ov_k2");
      st(0, 1, 4'h3, 0, 16'h0123, 3, 1, 0, 0, 0, "ov_k3");
      st(0, 1, 4'h4, 0, 16'h1234, 4, 1, 0, 0, 0, "ov_k4");
      st(0, 1, 4'h5, 0, 16'h1234, 4, 1, 0, 0, 0, "ov_k5");
      st(0, 1, 4'hC, 0, 16'h1234, 4, 1, 0, 0, 0, "ov_bad");
      st(0, 1, KC,   0, 16'h0000, 0, 1, 0, 0, 0, "ov_cancel");

      // Seconds tens > 5 rejected
      st(0, 1, 4'h9, 0, 16'h0009, 1, 1, 0, 0, 0, "r99_k9a");
      st(0, 1, 4'h9, 0, 16'h0099, 2, 1, 0, 0, 0, "r99_k9b");
      st(0, 1, KS,   0, 16'h0099, 2, 1, 0, 1, 0, "r99_err");
      st(0, 0, 4'h0, 0, 16'h0099, 2, 1, 0, 0, 0, "r99_err_end");
      st(0, 1, KC,   0, 16'h0000, 0, 1, 0, 0, 0, "r99_cancel");

      // Zero value rejected, entry continues afterwards
      st(0, 1, 4'h0, 0, 16'h0000, 1, 1, 0, 0, 0, "r0_k0");
      st(0, 1, KS,   0, 16'h0000, 1, 1, 0, 1, 0, "r0_err");
      st(0, 1, 4'h7, 0, 16'h0007, 2, 1, 0, 0, 0, "r0_k7");
      st(0, 1, KC,   0, 16'h0000, 0, 1, 0, 0, 0, "r0_cancel");

      // Cancel in RUN with simultaneous timer_zero: no done
      st(0, 1, 4'h5, 0, 16'h0005, 1, 1, 0, 0, 0, "cr_k5");
      st(0, 1, KS,   0, 16'h0005, 1, 0, 0, 0, 0, "cr_load");
      st(0, 0, 4'h0, 0, 16'h0005, 1, 1, 1, 0, 0, "cr_run1");
      st(0, 0, 4'h0, 0, 16'h0005, 1, 1, 1, 0, 0, "cr_run2");
      st(0, 0, 4'h0, 0, 16'h0005, 1, 1, 1, 0, 0, "cr_run3");
      st(0, 1, KC,   1, 16'h0000, 0, 1, 0, 0, 0, "cr_cancel");
      st(0, 0, 4'h0, 0, 16'h0000, 0, 1, 0, 0, 0, "cr_nodone");

      // Countdown finished: timer_zero in the fourth RUN cycle
      st(0, 1, 4'h5, 0, 16'h0005, 1, 1, 0, 0, 0, "dn_k5");
      st(0, 1, KS,   0, 16'h0005, 1, 0, 0, 0, 0, "dn_load");
      st(0, 0, 4'h0, 0, 16'h0005, 1, 1, 1, 0, 0, "dn_enter");
      st(0, 0, 4'h0, 0, 16'h0005, 1, 1, 1, 0, 0, "dn_c1");
      st(0, 0, 4'h0, 0, 16'h0005, 1, 1, 1, 0, 0, "dn_c2");
      st(0, 0, 4'h0, 0, 16'h0005, 1, 1, 1, 0, 0, "dn_c3");
      st(0, 0, 4'h0, 1, 16'h0000, 0, 1, 0, 0, 1, "dn_done");
      st(0, 0, 4'h0, 1, 16'h0000, 0, 1, 0, 0, 0, "dn_done_end");

      // timer_zero held from the first RUN cycle
      st(0, 1, 4'h2, 0, 16'h0002, 1, 1, 0, 0, 0, "hz_k2");
      st(0, 1, KS,   1, 16'h0002, 1, 0, 0, 0, 0, "hz_load");
      st(0, 0, 4'h0, 1, 16'h0002, 1, 1, 1, 0, 0, "hz_enter");
      st(0, 0, 4'h0, 1, 16'h0002, 1, 1, 1, 0, 0, "hz_first_ign");
      st(0, 0, 4'h0, 1, 16'h0000, 0, 1, 0, 0, 1, "hz_done");
      st(0, 0, 4'h0, 0, 16'h0000, 0, 1, 0, 0, 0, "hz_idle");

      // Reset mid-RUN together with START
      st(0, 1, 4'h4, 0, 16'h0004, 1, 1, 0, 0, 0, "rr_k4");
      st(0, 1, KS,   0, 16'h0004, 1, 0, 0, 0, 0, "rr_load");
      st(0, 0, 4'h0, 0, 16'h0004, 1, 1, 1, 0, 0, "rr_run1");
      st(0, 0, 4'h0, 0, 16'h0004, 1, 1, 1, 0, 0, "rr_run2");
      st(1, 1, KS,   0, 16'h0000, 0, 1, 0, 0, 0, "rr_clear");
      st(0, 0, 4'h0, 1, 16'h0000, 0, 1, 0, 0, 0, "rr_after");

      @(posedge clock);
      #2;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
